mole_draw_scheduler: RTL

Round-robin scheduler that shares the single rectangle-fill pixel engine between the game's draw requesters: background clear, hole refresh, mole pop-up and score bar. It accepts per-requester rectangle jobs, grants one at a time, and launches the engine with stable geometry and colour. It waits for engine completion, or aborts on a timeout, then acknowledges the requester. It sits between game logic and the pixel engine that feeds the VGA adapter's plot/x/y/colour inputs.

---
 rtl/mole_draw_scheduler.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/mole_draw_scheduler.sv
// Round-robin scheduler that shares one rectangle-fill engine between draw requesters.
// Latches the granted job, launches the engine, waits for done or timeout, then acks.
module mole_draw_scheduler #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 262143,
    parameter int TW      = 18
) (
    input  logic                clock,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [9*NREQ-1:0]   req_x,
    input  logic [8*NREQ-1:0]   req_y,
    input  logic [9*NREQ-1:0]   req_L,
    input  logic [8*NREQ-1:0]   req_W,
    input  logic [3*NREQ-1:0]   req_colour,
    input  logic                hold,
    input  logic                clr_err,
    input  logic                eng_done,
    output logic                eng_start,
    output logic [8:0]          eng_x,
    output logic [7:0]          eng_y,
    output logic [8:0]          eng_L,
    output logic [7:0]          eng_W,
    output logic [2:0]          eng_colour,
    output logic [NREQ-1:0]     ack,
    output logic [2:0]          grant_id,
    output logic                busy,
    output logic                err
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] ACK   = 2'd3;

    localparam logic [3:0]    NREQ_C    = 4'(NREQ);
    localparam logic [TW-1:0] TIMEOUT_C = TW'(TIMEOUT);

    logic [1:0]    state_r;
    logic [2:0]    rr_ptr_r;
    logic [TW-1:0] tmo_cnt_r;

    logic [3:0] dist_s;
    logic [3:0] best_d_s;
    logic       hit_s;
    logic [2:0] pick_id_s;
    logic       pick_valid_s;
    logic [8:0] pick_x_s;
    logic [7:0] pick_y_s;
    logic [8:0] pick_L_s;
    logic [7:0] pick_W_s;
    logic [2:0] pick_c_s;
    logic       sel_s;
    logic       zero_size_s;
    logic       tmo_hit_s;
    logic       err_set_s;
    logic [3:0] ptr_inc_s;
    logic [2:0] next_ptr_s;

    function automatic logic [NREQ-1:0] onehot(input logic [2:0] id);
        return NREQ'(1'b1) << id;
    endfunction

    // Round-robin pick: the requesting index closest above rr_ptr (with wrap) wins.
    always_comb begin
        best_d_s  = NREQ_C;
        pick_id_s = 3'd0;
        dist_s    = 4'd0;
        hit_s     = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            dist_s    = (4'(i) >= {1'b0, rr_ptr_r}) ? (4'(i) - {1'b0, rr_ptr_r})
                                                   : (4'(i) + NREQ_C - {1'b0, rr_ptr_r});
            hit_s     = req[i] && (dist_s < best_d_s);
            pick_id_s = hit_s ? 3'(i) : pick_id_s;
            best_d_s  = hit_s ? dist_s : best_d_s;
        end
        pick_valid_s = |req;
    end

    // Geometry mux for the picked requester.
    always_comb begin
        pick_x_s = 9'd0;
        pick_y_s = 8'd0;
        pick_L_s = 9'd0;
        pick_W_s = 8'd0;
        pick_c_s = 3'd0;
        sel_s    = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            sel_s    = (3'(i) == pick_id_s);
            pick_x_s = sel_s ? req_x[9*i +: 9]      : pick_x_s;
            pick_y_s = sel_s ? req_y[8*i +: 8]      : pick_y_s;
            pick_L_s = sel_s ? req_L[9*i +: 9]      : pick_L_s;
            pick_W_s = sel_s ? req_W[8*i +: 8]      : pick_W_s;
            pick_c_s = sel_s ? req_colour[3*i +: 3] : pick_c_s;
        end
        zero_size_s = (pick_L_s == 9'd0) || (pick_W_s == 8'd0);
    end

    // Timeout detection and round-robin pointer advance.
    always_comb begin
        tmo_hit_s  = ((tmo_cnt_r + TW'(1'b1)) == TIMEOUT_C);
        err_set_s  = (state_r == WAIT) && !eng_done && tmo_hit_s;
        ptr_inc_s  = {1'b0, grant_id} + 4'd1;
        next_ptr_s = (ptr_inc_s >= NREQ_C) ? 3'd0 : ptr_inc_s[2:0];
    end

    // Main job sequencer: grant, launch, wait, acknowledge.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            rr_ptr_r   <= 3'd0;
            tmo_cnt_r  <= {TW{1'b0}};
            eng_start  <= 1'b0;
            eng_x      <= 9'd0;
            eng_y      <= 8'd0;
            eng_L      <= 9'd0;
            eng_W      <= 8'd0;
            eng_colour <= 3'd0;
            ack        <= {NREQ{1'b0}};
            grant_id   <= 3'd0;
            busy       <= 1'b0;
        end else begin
            eng_start <= 1'b0;
            ack       <= {NREQ{1'b0}};
            case (state_r)
                IDLE: begin
                    if (!hold && pick_valid_s) begin
                        eng_x      <= pick_x_s;
                        eng_y      <= pick_y_s;
                        eng_L      <= pick_L_s;
                        eng_W      <= pick_W_s;
                        eng_colour <= pick_c_s;
                        grant_id   <= pick_id_s;
                        busy       <= 1'b1;
                        // Empty rectangles skip the engine entirely.
                        if (zero_size_s) begin
                            state_r <= ACK;
                            ack     <= onehot(pick_id_s);
                        end else begin
                            state_r   <= START;
                            eng_start <= 1'b1;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                START: begin
                    tmo_cnt_r <= {TW{1'b0}};
                    state_r   <= WAIT;
                end
                WAIT: begin
                    if (eng_done || tmo_hit_s) begin
                        state_r <= ACK;
                        ack     <= onehot(grant_id);
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + TW'(1'b1);
                    end
                end
                ACK: begin
                    rr_ptr_r <= next_ptr_s;
                    busy     <= 1'b0;
                    state_r  <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // Sticky timeout flag; a timeout in the same cycle as a clear wins.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            err <= 1'b0;
        end else if (err_set_s) begin
            err <= 1'b1;
        end else if (clr_err) begin
            err <= 1'b0;
        end else begin
            err <= err;
        end
    end

endmodule
